load_align_unit: RTL and testbench

- Sequential successor to the combinational load-extension stage in the MEM/WB path.
- Accepts a load request (byte address + load op), issues word-aligned read(s) to data memory, and merges bytes little-endian.
- Sign- or zero-extends the result and returns it on a valid/ready response port.
- Generalised over data width (32/64) and supports loads that cross a word boundary via a two-beat split.

---
 rtl/load_align_unit.sv | 169 ++++++++++++++++
 tb/tb_load_align_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Sequential load-alignment unit: word-aligned memory reads, little-endian byte merge, sign/zero extension.
// Optional macro LOAD_ALIGN_SPLIT_EN enables two-beat split of word-crossing loads (otherwise they fault).
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_op,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int SZ_W  = OFF_W + 2;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [2:0]        op_q;
  logic [OFF_W-1:0]  off_q;
  logic              cross_q;
  logic [DATA_W-1:0] beat0;
  logic [DATA_W-1:0] beat1;

  // Access size in bytes; 32-bit builds treat the word ops as full-width loads.
  function automatic logic [SZ_W-1:0] op_size(input logic [2:0] op);
    case (op)
      3'b001, 3'b010: return SZ_W'(1);
      3'b011, 3'b100: return SZ_W'(2);
      3'b101, 3'b110: return (DATA_W == 64) ? SZ_W'(4) : SZ_W'(BYTES);
      default:        return SZ_W'(BYTES);
    endcase
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    case (op)
      3'b010, 3'b100: return 1'b1;
      3'b110:         return (DATA_W == 64);
      default:        return 1'b0;
    endcase
  endfunction

  logic [OFF_W-1:0]  req_off;
  logic              req_cross;
  logic [ADDR_W-1:0] req_base;

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_cross = (SZ_W'(req_off) + op_size(req_op)) > SZ_W'(BYTES);
  assign req_base  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign req_ready = (state == IDLE);

  logic [DATA_W-1:0] low;
  logic [DATA_W-1:0] masked;
  logic [DATA_W-1:0] merged;
  logic [SZ_W-1:0]   diff;
  logic [SZ_W+2:0]   sh;

  // Shift the requested bytes down to bit 0, then push them to the top and back to extend.
  always_comb begin
    low    = DATA_W'({beat1, beat0} >> {off_q, 3'b000});
    diff   = SZ_W'(BYTES) - op_size(op_q);
    sh     = {diff, 3'b000};
    masked = low << sh;
    if (op_signed(op_q))
      merged = $signed(masked) >>> sh;
    else
      merged = masked >> sh;
  end

  assign rsp_data = (rsp_valid && !rsp_err) ? merged : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base_q    <= '0;
      op_q      <= '0;
      off_q     <= '0;
      cross_q   <= 1'b0;
      beat0     <= '0;
      beat1     <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            base_q  <= req_base;
            op_q    <= req_op;
            off_q   <= req_off;
            cross_q <= req_cross;
            beat0   <= '0;
            beat1   <= '0;
            rsp_err <= 1'b0;
`ifdef LOAD_ALIGN_SPLIT_EN
            mem_req  <= 1'b1;
            mem_addr <= req_base;
            state    <= REQ0;
`else
            if (req_cross) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= RESP;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= req_base;
              state    <= REQ0;
            end
`endif
          end
        end
        REQ0: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT0;
          end
        end
        WAIT0: begin
          if (mem_rvalid) begin
            beat0 <= mem_rdata;
            if (cross_q) begin
              mem_req  <= 1'b1;
              mem_addr <= base_q + ADDR_W'(BYTES);
              state    <= REQ1;
            end else begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        REQ1: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT1;
          end
        end
        WAIT1: begin
          if (mem_rvalid) begin
            beat1     <= mem_rdata;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: a 32-bit and a 64-bit instance share one stimulus/memory responder.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel64;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_op;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        rsp_ready;

  logic        req_ready_a, mem_req_a, rsp_valid_a, rsp_err_a;
  logic [31:0] mem_addr_a, rsp_data_a;
  logic        req_ready_b, mem_req_b, rsp_valid_b, rsp_err_b;
  logic [31:0] mem_addr_b;
  logic [63:0] rsp_data_b;

  logic        req_ready, mem_req, rsp_valid, rsp_err;
  logic [31:0] mem_addr;
  logic [63:0] rsp_data;

  always #5 clk = ~clk;

  load_align_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && !sel64), .req_ready(req_ready_a),
    .req_addr(req_addr), .req_op(req_op),
    .mem_req(mem_req_a), .mem_gnt(mem_gnt), .mem_addr(mem_addr_a),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_a), .rsp_err(rsp_err_a)
  );

  load_align_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && sel64), .req_ready(req_ready_b),
    .req_addr(req_addr), .req_op(req_op),
    .mem_req(mem_req_b), .mem_gnt(mem_gnt), .mem_addr(mem_addr_b),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_b), .rsp_err(rsp_err_b)
  );

  assign req_ready = sel64 ? req_ready_b : req_ready_a;
  assign mem_req   = sel64 ? mem_req_b   : mem_req_a;
  assign mem_addr  = sel64 ? mem_addr_b  : mem_addr_a;
  assign rsp_valid = sel64 ? rsp_valid_b : rsp_valid_a;
  assign rsp_err   = sel64 ? rsp_err_b   : rsp_err_a;
  assign rsp_data  = sel64 ? rsp_data_b  : {32'h0, rsp_data_a};

  int checks = 0;
  int errors = 0;

  logic [31:0] memA0, memA1;
  logic [63:0] memD0, memD1;

  int          nGnt, rspCycle, nRsp, extraRsp, unstable, readyBad;
  logic [31:0] gotAddr0, gotAddr1;
  logic [63:0] rspData;
  logic        rspErr, postReady, postValid;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] memRead(input logic [31:0] a);
    if (a == memA0) return memD0;
    if (a == memA1) return memD1;
    return 64'h0;
  endfunction

  // Issues one load and plays the memory and consumer with the given wait counts.
  task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] op,
                               input int gntWait, input int rvWait, input int rspWait);
    int cyc, holdCnt, rvCnt, rspHold;
    logic pending, done;
    logic [31:0] firstAddr;
    nGnt = 0; rspCycle = -1; nRsp = 0; extraRsp = 0; unstable = 0; readyBad = 0;
    gotAddr0 = '0; gotAddr1 = '0; rspData = '0; rspErr = 1'b0;
    holdCnt = 0; rvCnt = 0; rspHold = 0; pending = 1'b0; done = 1'b0; firstAddr = '0;
    req_valid = 1'b1; req_addr = addr; req_op = op;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~addr; req_op = 3'b010;
    cyc = 1;
    while (!done && cyc < 80) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; rsp_ready = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (req_ready) readyBad++;
      if (mem_req) begin
        if (holdCnt == 0) firstAddr = mem_addr;
        else if (mem_addr !== firstAddr) unstable++;
        if (holdCnt == gntWait) begin
          mem_gnt = 1'b1;
          if (nGnt == 0) gotAddr0 = mem_addr; else gotAddr1 = mem_addr;
          nGnt++;
          pending = 1'b1;
          rvCnt = rvWait;
          holdCnt = 0;
        end else holdCnt++;
      end else if (pending) begin
        if (rvCnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = memRead(nGnt == 1 ? gotAddr0 : gotAddr1);
          pending = 1'b0;
        end else rvCnt--;
      end
      if (rsp_valid) begin
        if (rspHold == 0) begin
          rspCycle = cyc; rspData = rsp_data; rspErr = rsp_err;
        end else if (rsp_data !== rspData || rsp_err !== rspErr) unstable++;
        if (rspHold == rspWait) begin
          rsp_ready = 1'b1; nRsp++; done = 1'b1;
        end else rspHold++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; rsp_ready = 1'b0;
    if (!done) checkOutput("timeout", 64'd0, 64'd1);
    postReady = req_ready;
    postValid = rsp_valid;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid) extraRsp++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; sel64 = 1'b0; req_valid = 1'b0; req_addr = '0; req_op = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
    memA0 = '0; memA1 = 32'hFFFF_FFF0; memD0 = '0; memD1 = '0;
    #12;
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_req_ready", req_ready, 1);

    $display("[TB] lb at 0x103, zero-wait memory");
    memA0 = 32'h100; memD0 = 64'h80AA_BBCC;
    applyStimulus(32'h103, 3'b010, 0, 0, 0);
    checkOutput("lb_data", rspData, 64'hFFFF_FF80);
    checkOutput("lb_err", rspErr, 0);
    checkOutput("lb_latency", rspCycle, 3);
    checkOutput("lb_addr", gotAddr0, 32'h100);
    checkOutput("lb_beats", nGnt, 1);
    checkOutput("lb_ready_after", postReady, 1);
    checkOutput("lb_valid_after", postValid, 0);

    $display("[TB] lhu at 0x101, misaligned single beat");
    memD0 = 64'h1234_5678;
    applyStimulus(32'h101, 3'b011, 0, 0, 0);
    checkOutput("lhu_data", rspData, 64'h3456);
    checkOutput("lhu_addr", gotAddr0, 32'h100);
    checkOutput("lhu_beats", nGnt, 1);

    $display("[TB] lh at 0x103, crossing load");
    memD0 = 64'hAB00_0000; memA1 = 32'h104; memD1 = 64'h0000_00CD;
    applyStimulus(32'h103, 3'b100, 0, 0, 0);
`ifdef LOAD_ALIGN_SPLIT_EN
    checkOutput("cross_beats", nGnt, 2);
    checkOutput("cross_addr0", gotAddr0, 32'h100);
    checkOutput("cross_addr1", gotAddr1, 32'h104);
    checkOutput("cross_data", rspData, 64'hFFFF_CDAB);
    checkOutput("cross_err", rspErr, 0);
    checkOutput("cross_latency", rspCycle, 5);
`else
    checkOutput("cross_beats", nGnt, 0);
    checkOutput("cross_data", rspData, 0);
    checkOutput("cross_err", rspErr, 1);
    checkOutput("cross_latency", rspCycle, 1);
`endif
    checkOutput("cross_ready_after", postReady, 1);

    $display("[TB] lh at 0x102, ends exactly at word boundary");
    memD0 = 64'h8001_0000;
    applyStimulus(32'h102, 3'b100, 0, 0, 0);
    checkOutput("lh_edge_data", rspData, 64'hFFFF_8001);
    checkOutput("lh_edge_beats", nGnt, 1);

    $display("[TB] lbu at 0x202 and op 111 as full word");
    memA0 = 32'h200; memD0 = 64'h1280_3456;
    applyStimulus(32'h202, 3'b001, 0, 0, 0);
    checkOutput("lbu_data", rspData, 64'h80);
    memA0 = 32'h8; memD0 = 64'h1122_3344;
    applyStimulus(32'h8, 3'b111, 0, 0, 0);
    checkOutput("op7_data", rspData, 64'h1122_3344);
    applyStimulus(32'h8, 3'b110, 0, 0, 0);
    checkOutput("lw32_data", rspData, 64'h1122_3344);

    $display("[TB] backpressure on grant, read data and response");
    memA0 = 32'h200; memD0 = 64'hDEAD_BEEF;
    applyStimulus(32'h200, 3'b000, 3, 3, 2);
    checkOutput("bp_data", rspData, 64'hDEAD_BEEF);
    checkOutput("bp_unstable", unstable, 0);
    checkOutput("bp_ready_low", readyBad, 0);
    checkOutput("bp_rsp_count", nRsp + extraRsp, 1);
    checkOutput("bp_latency", rspCycle, 9);
    checkOutput("bp_addr", gotAddr0, 32'h200);

    $display("[TB] 64-bit lw / lwu / full word");
    sel64 = 1'b1;
    memA0 = 32'h0; memD0 = 64'h8000_0001_0000_0000;
    applyStimulus(32'h4, 3'b110, 0, 0, 0);
    checkOutput("lw64_data", rspData, 64'hFFFF_FFFF_8000_0001);
    checkOutput("lw64_addr", gotAddr0, 32'h0);
    applyStimulus(32'h4, 3'b101, 0, 0, 0);
    checkOutput("lwu64_data", rspData, 64'h0000_0000_8000_0001);
    applyStimulus(32'h0, 3'b000, 0, 0, 0);
    checkOutput("full64_data", rspData, 64'h8000_0001_0000_0000);
    sel64 = 1'b0;

    $display("[TB] reset mid-transaction, then a stray read response");
    memA0 = 32'h100; memD0 = 64'hAB00_0000; memA1 = 32'h104; memD1 = 64'hCD;
    req_valid = 1'b1; req_op = 3'b100;
`ifdef LOAD_ALIGN_SPLIT_EN
    req_addr = 32'h103;
`else
    req_addr = 32'h100;
`endif
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
`ifdef LOAD_ALIGN_SPLIT_EN
    mem_rvalid = 1'b1; mem_rdata = memD0;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
`endif
    checkOutput("kill_busy", req_ready, 0);
    rst_n = 1'b0;
    #2;
    checkOutput("kill_mem_req", mem_req, 0);
    checkOutput("kill_mem_addr", mem_addr, 0);
    checkOutput("kill_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = memD1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    extraRsp = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid || mem_req) extraRsp++;
      @(posedge clk); #1;
    end
    checkOutput("kill_no_activity", extraRsp, 0);
    checkOutput("kill_req_ready", req_ready, 1);
    checkOutput("kill_rsp_data", rsp_data, 0);
    checkOutput("kill_rsp_err", rsp_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
